// File: rtl/prio_req_pkg.sv
// Shared types, defaults and width helpers for the req/gnt priority issuer.
package prio_req_pkg;

  localparam int DEF_CNT_W        = 2;
  localparam int DEF_STARVE_LIMIT = 8;

  typedef struct packed {
    logic ovf;
    logic starve;
  } lane_status_t;

  // Floor of 1 keeps index ports legal even for degenerate sizes.
  function automatic int idx_w(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

endpackage

// File: rtl/prio_req_lane.sv
// One lane: pending-token counter, overflow pulse and optional starvation watchdog
// (watchdog built only when PRIO_REQ_ISSUER_STARVE_WATCHDOG_EN is defined).
module prio_req_lane
  import prio_req_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         new_req,
  input  logic         take,
  output logic         req,
  output lane_status_t status
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             starve_w;

  // take is only ever asserted while the lane is requesting, so cnt_q > 0 on decrement.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    if (new_req && !take) begin
      if (cnt_q == CNT_MAX) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (!new_req && take) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign req = |cnt_q;

`ifdef PRIO_REQ_ISSUER_STARVE_WATCHDOG_EN
  localparam int                WAIT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

  logic [WAIT_W-1:0] wait_q, wait_d;

  always_comb begin
    wait_d = wait_q;
    if (!req || take) begin
      wait_d = '0;
    end else if (wait_q != WAIT_MAX) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end

  assign starve_w = (wait_q == WAIT_MAX);
`else
  assign starve_w = 1'b0;
`endif

  assign status = '{ovf: ovf_q, starve: starve_w};

endmodule

// File: rtl/prio_req_issuer.sv
// Requester side of a req/gnt fixed-priority arbiter: token queues, grant legality,
// grant index reporting; starvation flags when PRIO_REQ_ISSUER_STARVE_WATCHDOG_EN is defined.
module prio_req_issuer
  import prio_req_pkg::*;
#(
  parameter int SIZE         = 4,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [SIZE-1:0]          new_req,
  output logic [SIZE-1:0]          req,
  input  logic [SIZE-1:0]          gnt,
  output logic                     gnt_vld,
  output logic [idx_w(SIZE)-1:0]   gnt_idx,
  output logic [SIZE-1:0]          ovf_err,
  output logic                     proto_err,
  output logic [SIZE-1:0]          starve,
  output logic                     busy
);

  localparam int IDX_W = idx_w(SIZE);

  logic [SIZE-1:0]  take;
  logic             multi_hot;
  logic             stray;
  logic             legal;
  logic             grant_ok;
  logic [IDX_W-1:0] idx_enc;
  lane_status_t     status_w [SIZE];

  logic             gnt_vld_q;
  logic [IDX_W-1:0] gnt_idx_q;
  logic             proto_err_q;

  // Illegal grants consume nothing, but lanes still accept new tokens.
  assign multi_hot = |(gnt & (gnt - 1'b1));
  assign stray     = |(gnt & ~req);
  assign legal     = !multi_hot && !stray;
  assign grant_ok  = legal && (|gnt);
  assign take      = legal ? gnt : '0;

  generate
    for (genvar gi = 0; gi < SIZE; gi++) begin : g_lane
      prio_req_lane #(
        .CNT_W        (CNT_W),
        .STARVE_LIMIT (STARVE_LIMIT)
      ) u_lane (
        .clk     (clk),
        .rst     (rst),
        .new_req (new_req[gi]),
        .take    (take[gi]),
        .req     (req[gi]),
        .status  (status_w[gi])
      );
      assign ovf_err[gi] = status_w[gi].ovf;
      assign starve[gi]  = status_w[gi].starve;
    end
  endgenerate

  always_comb begin
    idx_enc = '0;
    for (int i = 0; i < SIZE; i++) begin
      if (gnt[i]) begin
        idx_enc = i[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_vld_q   <= 1'b0;
      gnt_idx_q   <= '0;
      proto_err_q <= 1'b0;
    end else begin
      gnt_vld_q   <= grant_ok;
      proto_err_q <= !legal;
      if (grant_ok) begin
        gnt_idx_q <= idx_enc;
      end
    end
  end

  assign gnt_vld   = gnt_vld_q;
  assign gnt_idx   = gnt_idx_q;
  assign proto_err = proto_err_q;
  assign busy      = |req;

endmodule
